hamming_weight_pkt_rx: RTL

//  Parametrised packet receiver: waits for a START_TOKEN word, then consumes PKT_WORDS data words,

---
 rtl/hamming_pkg.sv | 14 +
 rtl/hamming_weight_pkt_rx_popcount_scan.sv | 32 +++
 rtl/hamming_weight_pkt_rx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared types and width helper for the Hamming-weight packet receiver.
package hamming_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } rx_state_t;

  // Bits needed to hold n distinct values, never less than one.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hamming_weight_pkt_rx_popcount_scan.sv
// Combinational summary of one data word: popcount and lowest/highest set-bit index.
module popcount_scan
  import hamming_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = width_of(DATA_W + 1),
  parameter int IDX_W  = width_of(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  cnt,
  output logic              any,
  output logic [IDX_W-1:0]  lo_idx,
  output logic [IDX_W-1:0]  hi_idx
);

  always_comb begin
    cnt    = '0;
    lo_idx = '0;
    hi_idx = '0;
    for (int i = 0; i < DATA_W; i++) begin
      cnt = cnt + CNT_W'(data[i]);
      if (data[i]) hi_idx = IDX_W'(i);
    end
    // Scanning downwards leaves the lowest set bit as the final assignment.
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (data[i]) lo_idx = IDX_W'(i);
    end
  end

  assign any = |data;

endmodule

// File: rtl/hamming_weight_pkt_rx.sv
// Packet receiver: after a start token, accumulates Hamming weight and first/last set-bit positions.
module hamming_weight_pkt_rx
  import hamming_pkg::*;
#(
  parameter int              DATA_W      = 8,
  parameter int              PKT_WORDS   = 128,
  parameter logic [DATA_W-1:0] START_TOKEN = {DATA_W{1'b1}},
  parameter int              WT_W        = width_of(DATA_W * PKT_WORDS + 1),
  parameter int              POS_W       = width_of(DATA_W * PKT_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              abort,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WT_W-1:0]   res_weight,
  output logic [POS_W-1:0]  res_first,
  output logic [POS_W-1:0]  res_last,
  output logic              res_zero,
  output logic              overrun
);

  localparam int CNT_W = width_of(DATA_W + 1);
  localparam int IDX_W = width_of(DATA_W);
  localparam int WC_W  = width_of(PKT_WORDS);

  rx_state_t         state, state_nxt;
  logic [WC_W-1:0]   word_cnt;
  logic [WT_W-1:0]   acc_wt;
  logic [POS_W-1:0]  acc_first, acc_last;
  logic              seen_one;

  logic [CNT_W-1:0]  scan_cnt;
  logic              scan_any;
  logic [IDX_W-1:0]  scan_lo, scan_hi;

  popcount_scan #(.DATA_W(DATA_W)) u_scan (
    .data   (in_data),
    .cnt    (scan_cnt),
    .any    (scan_any),
    .lo_idx (scan_lo),
    .hi_idx (scan_hi)
  );

  logic              start_hit, acc_beat, last_beat;
  logic [POS_W-1:0]  base_pos;
  logic [WT_W-1:0]   wt_nxt;
  logic [POS_W-1:0]  first_nxt, last_nxt;
  logic              seen_nxt;

  // Abort suppresses both a start in IDLE and any beat (including the last) in ACC.
  assign start_hit = (state == IDLE) && in_valid && (in_data == START_TOKEN) && !abort;
  assign acc_beat  = (state == ACC) && in_valid && !abort;
  assign last_beat = acc_beat && (word_cnt == WC_W'(PKT_WORDS - 1));

  assign base_pos  = POS_W'(word_cnt) * POS_W'(DATA_W);
  assign wt_nxt    = acc_wt + WT_W'(scan_cnt);
  assign first_nxt = (!seen_one && scan_any) ? base_pos + POS_W'(scan_lo) : acc_first;
  assign last_nxt  = scan_any ? base_pos + POS_W'(scan_hi) : acc_last;
  assign seen_nxt  = seen_one | scan_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_hit) state_nxt = ACC;
      ACC:     if (abort || last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ACC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt  <= '0;
      acc_wt    <= '0;
      acc_first <= '0;
      acc_last  <= '0;
      seen_one  <= 1'b0;
    end else if (start_hit) begin
      word_cnt  <= '0;
      acc_wt    <= '0;
      acc_first <= '0;
      acc_last  <= '0;
      seen_one  <= 1'b0;
    end else if (acc_beat) begin
      word_cnt  <= word_cnt + WC_W'(1);
      acc_wt    <= wt_nxt;
      acc_first <= first_nxt;
      acc_last  <= last_nxt;
      seen_one  <= seen_nxt;
    end
  end

  // Result loads straight from the next-state accumulators so it appears one cycle after the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_weight <= '0;
      res_first  <= '0;
      res_last   <= '0;
      res_zero   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= last_beat && res_valid && !res_ready;
      if (last_beat) begin
        res_valid  <= 1'b1;
        res_weight <= wt_nxt;
        res_first  <= first_nxt;
        res_last   <= last_nxt;
        res_zero   <= !seen_nxt;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
